// File: rtl/syscall_unit.sv
// Syscall service unit: stalls decode on a syscall, waits for $v0/$a0 writes to
// retire, then prints an int/char over valid/ready, halts, or flags a bad code.
module syscall_unit #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param1,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [1:0]  out_kind,
    output logic [31:0] out_data,
    output logic        stall,
    output logic        halted,
    output logic        bad_syscall
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_EMIT,
        ST_RELEASE,
        ST_HALT
    } state_t;

    localparam logic [3:0]  DRAIN_LOAD    = 4'(DRAIN_CYCLES);
    localparam logic [31:0] FN_PRINT_INT  = 32'd1;
    localparam logic [31:0] FN_EXIT       = 32'd10;
    localparam logic [31:0] FN_PRINT_CHAR = 32'd11;
    localparam logic [1:0]  KIND_INT      = 2'd1;
    localparam logic [1:0]  KIND_CHAR     = 2'd2;

    state_t      state, state_nxt;
    logic [3:0]  count, count_nxt;
    logic [1:0]  kind_q, kind_nxt;
    logic [31:0] data_q, data_nxt;
    logic        bad_q, bad_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            count  <= 4'd0;
            kind_q <= 2'd0;
            data_q <= 32'd0;
            bad_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            kind_q <= kind_nxt;
            data_q <= data_nxt;
            bad_q  <= bad_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        kind_nxt  = kind_q;
        data_nxt  = data_q;
        bad_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (syscall_valid) begin
                    state_nxt = ST_DRAIN;
                    count_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                count_nxt = count - 4'd1;
                if (count == 4'd1) begin
                    // Last drain cycle: $v0/$a0 are final, capture them at this edge.
                    if (syscall_funct == FN_PRINT_INT) begin
                        state_nxt = ST_EMIT;
                        kind_nxt  = KIND_INT;
                        data_nxt  = syscall_param1;
                    end else if (syscall_funct == FN_PRINT_CHAR) begin
                        state_nxt = ST_EMIT;
                        kind_nxt  = KIND_CHAR;
                        data_nxt  = {24'd0, syscall_param1[7:0]};
                    end else if (syscall_funct == FN_EXIT) begin
                        state_nxt = ST_HALT;
                    end else begin
                        state_nxt = ST_RELEASE;
                        bad_nxt   = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            ST_HALT:    state_nxt = ST_HALT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign stall       = ((state == ST_IDLE) && syscall_valid) || (state == ST_DRAIN)
                       || (state == ST_EMIT) || (state == ST_HALT);
    assign out_valid   = (state == ST_EMIT);
    assign out_kind    = out_valid ? kind_q : 2'd0;
    assign out_data    = out_valid ? data_q : 32'd0;
    assign halted      = (state == ST_HALT);
    assign bad_syscall = bad_q;

endmodule
